block_fetch_mem: RTL and testbench
==================================

# block_fetch_mem

Main-memory block fetch unit on the refill side of the 4096-entry direct-mapped data cache. On a miss the cache raises a fetch request with the 15-bit word address. This block reads four consecutive 32-bit words from a 32K-word backing store, one word every LATENCY cycles. It then presents them on data1..data4 and pulses done, so the cache refill can write the block. The backing store is preloaded through a separate write port.

## Interface
- ADDR_W, 15, word address width; backing store holds 2^ADDR_W words
- DATA_W, 32, word width
- LATENCY, 4, cycles per word read; legal range 1..15
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-low
- req  in  1  fetch request, level; sampled only in IDLE
- req_addr  in  ADDR_W  first word address of block; sampled with req
- busy  out  1  high from the edge accepting req until the edge leaving DONE
- done  out  1  one-cycle pulse; data1..data4 valid
- data1..data4  out  DATA_W each  words at base, base+1, base+2, base+3
- wr_en  in  1  backing-store write enable
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- fetch_count  out  16  completed fetches, saturates at 0xFFFF

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - req=1 latches base=req_addr, idx=0, cnt=LATENCY-1; go to WAIT.
  - req=0 stays in IDLE.
- WAIT:
  - cnt!=0: cnt decrements.
  - cnt==0: word[idx] captures mem[base+idx].
  - After capture, if idx==3 go to DONE; else idx increments and cnt reloads LATENCY-1.
- DONE: done=1 for exactly one cycle; fetch_count increments unless saturated; next state IDLE.
- Address arithmetic is modulo 2^ADDR_W. Base 0x7FFE fetches 0x7FFE, 0x7FFF, 0x0000, 0x0001.
- req while busy is ignored, not queued. req held high through DONE is re-accepted in the following IDLE cycle.
- data1..data4 hold their values from capture until overwritten by the next fetch. Unfetched words keep their old contents.
- The backing store has a synchronous write and an asynchronous read.
- wr_en is honoured in every state.
- Write and capture on the same edge at the same address: the capture takes the OLD word. A write landing before the capture edge is seen by the capture.
- Reset (any time, including mid-fetch):
  - state=IDLE, busy=0, done=0, data1..data4=0, fetch_count=0.
  - The in-flight fetch is abandoned; no done pulse.
  - Backing store contents are not reset.

## Timing
- Let E0 be the edge accepting req. Word k (k=0..3) is captured at edge E0+(k+1)*LATENCY.
- done is high during the cycle after edge E0+4*LATENCY. busy falls at edge E0+4*LATENCY+1.
- With LATENCY=4, done rises 16 cycles after acceptance. The earliest next acceptance is at E0+18 (req high in the IDLE cycle).
- busy is registered and rises in the cycle after E0.
- done and fetch_count update are registered; there is no combinational path from req to any output.

## Structure
- Package block_fetch_pkg holds:
  - ADDR_W and DATA_W defaults
  - BLOCK_WORDS=4
  - state enum (IDLE, WAIT, DONE)
- One sub-module, main_mem_array: 2^ADDR_W x DATA_W storage with sync write and async read, taking the read address from the FSM (base+idx).
- The top level holds the FSM, cnt/idx counters, the four data registers and fetch_count.

## Test plan
- Basic fetch:
  - Stimulus: preload mem[0x0100..0x0103]=0xA0..0xA3; LATENCY=4; req pulse with addr 0x0100.
  - Response: done exactly 16 cycles after acceptance; data1..4=0xA0..0xA3; fetch_count=1.
- Wrap:
  - Stimulus: preload 0x7FFE=0x11, 0x7FFF=0x22, 0x0000=0x33, 0x0001=0x44; req addr 0x7FFE.
  - Response: data1..4=0x11, 0x22, 0x33, 0x44.
- Busy request:
  - Stimulus: second req with addr 0x0200 issued 3 cycles into a fetch of 0x0100, then dropped.
  - Response: only one done; data from 0x0100; fetch_count=1.
- Mid-fetch reset:
  - Stimulus: assert rst low 6 cycles into a fetch.
  - Response: outputs zero immediately, without waiting for a clock edge; no done; a fresh req afterwards completes normally.
- Write collision:
  - Stimulus: write 0x55 to base+2 on its capture edge.
  - Response: data3 holds the old word. The same write one cycle earlier makes data3=0x55.
- Saturation and minimum latency:
  - Stimulus: force fetch_count to 0xFFFF and complete a fetch; separately run LATENCY=1.
  - Response: fetch_count stays 0xFFFF; with LATENCY=1, done arrives 4 cycles after acceptance.

Source files
------------

// File: rtl/block_fetch_mem_pkg.sv
// Shared widths, block geometry and FSM state encoding for the cache refill fetch unit.
package block_fetch_pkg;

    localparam int DEF_ADDR_W = 15;
    localparam int DEF_DATA_W = 32;
    localparam int unsigned BLOCK_WORDS = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = S_IDLE,
        WAIT = S_WAIT,
        DONE = S_DONE
    } state_t;

endpackage

// File: rtl/block_fetch_mem_if.sv
// Fetch request/response and backing-store preload port between the cache and the fetch unit.
interface block_fetch_mem_if
    import block_fetch_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              req;
    logic [ADDR_W-1:0] req_addr;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
    logic [DATA_W-1:0] data3;
    logic [DATA_W-1:0] data4;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [15:0]       fetch_count;

    modport master (
        output req, req_addr, wr_en, wr_addr, wr_data,
        input  busy, done, data1, data2, data3, data4, fetch_count
    );

    modport slave (
        input  req, req_addr, wr_en, wr_addr, wr_data,
        output busy, done, data1, data2, data3, data4, fetch_count
    );
endinterface

// File: rtl/block_fetch_mem_mem.sv
// Backing store: synchronous write, asynchronous read, contents never reset.
module main_mem_array
    import block_fetch_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/block_fetch_mem.sv
// Refill-side block fetch: reads four consecutive words, one per LATENCY cycles, then pulses done.
module block_fetch_mem
    import block_fetch_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int LATENCY = 4
) (
    input logic              clk,
    input logic              rst,
    block_fetch_mem_if.slave bus
);
    localparam logic [3:0] CNT_RELOAD = 4'(LATENCY - 1);

    state_t            state;
    logic [ADDR_W-1:0] base;
    logic [1:0]        idx;
    logic [3:0]        cnt;
    logic [15:0]       fetch_count_q;
    logic [DATA_W-1:0] word_q [BLOCK_WORDS];
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    // Truncation to ADDR_W gives the modulo wrap past the top of the store.
    assign rd_addr = base + ADDR_W'(idx);

    main_mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (bus.wr_en),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            base          <= '0;
            idx           <= '0;
            cnt           <= '0;
            fetch_count_q <= '0;
            for (int unsigned i = 0; i < BLOCK_WORDS; i++) begin
                word_q[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        base  <= bus.req_addr;
                        idx   <= '0;
                        cnt   <= CNT_RELOAD;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        word_q[idx] <= rd_data;
                        if (idx == 2'd3) begin
                            state <= DONE;
                        end else begin
                            idx <= idx + 2'd1;
                            cnt <= CNT_RELOAD;
                        end
                    end
                end
                DONE: begin
                    if (fetch_count_q != '1) begin
                        fetch_count_q <= fetch_count_q + 16'd1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy        = (state != IDLE);
    assign bus.done        = (state == DONE);
    assign bus.data1       = word_q[0];
    assign bus.data2       = word_q[1];
    assign bus.data3       = word_q[2];
    assign bus.data4       = word_q[3];
    assign bus.fetch_count = fetch_count_q;
endmodule

// File: tb/tb_block_fetch_mem.sv
// Scoreboard bench for block_fetch_mem: LATENCY=4 main instance plus a LATENCY=1 instance.
module tb_block_fetch_mem;
    typedef logic [3:0][31:0] blk_t;

    logic clk;
    logic rst;

    block_fetch_mem_if bus ();
    block_fetch_mem_if bus1 ();

    block_fetch_mem #(.ADDR_W(15), .DATA_W(32), .LATENCY(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    block_fetch_mem #(.ADDR_W(15), .DATA_W(32), .LATENCY(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    assign bus1.wr_en   = bus.wr_en;
    assign bus1.wr_addr = bus.wr_addr;
    assign bus1.wr_data = bus.wr_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    blk_t sb_q[$];
    logic [31:0] model [logic [14:0]];
    int   exp_count;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_write(input logic [14:0] a, input logic [31:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        tick();
        bus.wr_en   = 1'b0;
        model[a]    = d;
    endtask

    function automatic blk_t model_block(input logic [14:0] base);
        blk_t b;
        for (int k = 0; k < 4; k++) begin
            logic [14:0] a;
            a = base + 15'(k);
            b[k] = model.exists(a) ? model[a] : 32'h0;
        end
        return b;
    endfunction

    // Drive one accepted request; returns at +1ns after the accepting edge.
    task automatic start_fetch(input logic sel, input logic [14:0] a, input blk_t exp);
        sb_q.push_back(exp);
        if (sel) begin
            bus1.req = 1'b1; bus1.req_addr = a;
        end else begin
            bus.req = 1'b1; bus.req_addr = a;
        end
        tick();
        bus.req  = 1'b0;
        bus1.req = 1'b0;
    endtask

    task automatic wait_done(input logic sel, input int budget, output int cyc);
        cyc = 0;
        while (!(sel ? bus1.done : bus.done) && cyc < budget) begin
            tick();
            cyc++;
        end
        check_eq("done_seen", 32'(sel ? bus1.done : bus.done), 32'd1);
    endtask

    task automatic compare_block(input logic sel, input string tag);
        blk_t got, exp;
        if (sel) begin
            got = {bus1.data4, bus1.data3, bus1.data2, bus1.data1};
        end else begin
            got = {bus.data4, bus.data3, bus.data2, bus.data1};
        end
        check_eq({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
            exp = sb_q.pop_front();
            for (int k = 0; k < 4; k++) begin
                check_eq($sformatf("%s_data%0d", tag, k + 1), got[k], exp[k]);
            end
        end
    endtask

    task automatic full_fetch(input logic [14:0] a, input string tag);
        int cyc;
        start_fetch(1'b0, a, model_block(a));
        wait_done(1'b0, 40, cyc);
        compare_block(1'b0, tag);
        tick();
        exp_count = (exp_count == 32'hFFFF) ? exp_count : exp_count + 1;
        check_eq({tag, "_count"}, 32'(bus.fetch_count), 32'(exp_count));
    endtask

    initial begin
        int   cyc;
        int   n_done;
        blk_t e;

        rst = 1'b0;
        bus.req = 1'b0;  bus.req_addr = '0;
        bus1.req = 1'b0; bus1.req_addr = '0;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        exp_count = 0;

        repeat (3) tick();
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_done", 32'(bus.done), 32'd0);
        check_eq("rst_d1", bus.data1, 32'd0);
        check_eq("rst_d4", bus.data4, 32'd0);
        check_eq("rst_count", 32'(bus.fetch_count), 32'd0);
        rst = 1'b1;
        tick();

        for (int k = 0; k < 4; k++) mem_write(15'h0100 + 15'(k), 32'hA0 + 32'(k));
        for (int k = 0; k < 4; k++) mem_write(15'h0200 + 15'(k), 32'hB0 + 32'(k));
        for (int k = 0; k < 4; k++) mem_write(15'h0300 + 15'(k), 32'hC0 + 32'(k));
        mem_write(15'h7FFE, 32'h11);
        mem_write(15'h7FFF, 32'h22);
        mem_write(15'h0000, 32'h33);
        mem_write(15'h0001, 32'h44);

        // Basic fetch with exact latency and busy timing
        start_fetch(1'b0, 15'h0100, model_block(15'h0100));
        check_eq("basic_busy_rise", 32'(bus.busy), 32'd1);
        wait_done(1'b0, 40, cyc);
        check_eq("basic_latency", 32'(cyc), 32'd16);
        compare_block(1'b0, "basic");
        tick();
        check_eq("basic_busy_fall", 32'(bus.busy), 32'd0);
        check_eq("basic_done_fall", 32'(bus.done), 32'd0);
        exp_count = 1;
        check_eq("basic_count", 32'(bus.fetch_count), 32'(exp_count));

        full_fetch(15'h7FFE, "wrap");

        // Request while busy must be dropped
        start_fetch(1'b0, 15'h0100, model_block(15'h0100));
        repeat (3) tick();
        bus.req = 1'b1; bus.req_addr = 15'h0200;
        tick();
        bus.req = 1'b0;
        wait_done(1'b0, 40, cyc);
        compare_block(1'b0, "busyreq");
        n_done = 0;
        repeat (25) begin
            tick();
            if (bus.done) n_done++;
        end
        check_eq("busyreq_single_done", 32'(n_done), 32'd0);
        exp_count++;
        check_eq("busyreq_count", 32'(bus.fetch_count), 32'(exp_count));

        // Mid-fetch asynchronous reset
        start_fetch(1'b0, 15'h0200, model_block(15'h0200));
        repeat (6) tick();
        #2 rst = 1'b0;
        #1;
        check_eq("arst_busy", 32'(bus.busy), 32'd0);
        check_eq("arst_d1", bus.data1, 32'd0);
        check_eq("arst_d3", bus.data3, 32'd0);
        check_eq("arst_count", 32'(bus.fetch_count), 32'd0);
        void'(sb_q.pop_back());
        exp_count = 0;
        n_done = 0;
        repeat (3) begin
            tick();
            if (bus.done) n_done++;
        end
        rst = 1'b1;
        repeat (20) begin
            tick();
            if (bus.done) n_done++;
        end
        check_eq("arst_no_done", 32'(n_done), 32'd0);
        full_fetch(15'h0200, "after_rst");

        // Write on the capture edge of word 2: capture sees the old word
        e = model_block(15'h0300);
        start_fetch(1'b0, 15'h0300, e);
        repeat (11) tick();
        bus.wr_en = 1'b1; bus.wr_addr = 15'h0302; bus.wr_data = 32'h55;
        tick();
        bus.wr_en = 1'b0;
        model[15'h0302] = 32'h55;
        wait_done(1'b0, 40, cyc);
        compare_block(1'b0, "coll_same");
        tick();
        exp_count++;

        // Same write one cycle earlier is seen by the capture
        mem_write(15'h0302, 32'hC2);
        e = model_block(15'h0300);
        e[2] = 32'h55;
        start_fetch(1'b0, 15'h0300, e);
        repeat (10) tick();
        bus.wr_en = 1'b1; bus.wr_addr = 15'h0302; bus.wr_data = 32'h55;
        tick();
        bus.wr_en = 1'b0;
        model[15'h0302] = 32'h55;
        wait_done(1'b0, 40, cyc);
        compare_block(1'b0, "coll_early");
        tick();
        exp_count++;
        check_eq("coll_count", 32'(bus.fetch_count), 32'(exp_count));

        // Saturation
        force dut.fetch_count_q = 16'hFFFF;
        #1;
        release dut.fetch_count_q;
        #1;
        check_eq("sat_preset", 32'(bus.fetch_count), 32'hFFFF);
        exp_count = 32'hFFFF;
        full_fetch(15'h0100, "sat");

        // Minimum latency instance
        start_fetch(1'b1, 15'h0100, model_block(15'h0100));
        wait_done(1'b1, 20, cyc);
        check_eq("lat1_latency", 32'(cyc), 32'd4);
        compare_block(1'b1, "lat1");
        tick();
        check_eq("lat1_busy_fall", 32'(bus1.busy), 32'd0);
        check_eq("lat1_count", 32'(bus1.fetch_count), 32'd1);

        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
